// File: rtl/pc_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch : fetch PC register, single-outstanding imem fetch, instr buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] npc_i,
  output logic [31:0] pc_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [31:0]   tag_pc;
  logic          discard;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign if_valid  = (count != '0);
  assign pop       = if_valid & if_ready;
  assign push      = (state == WAIT) & imem_rvalid & ~discard & ~redirect;

  assign pc_o      = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = (state == REQ);
  assign if_pc     = if_valid ? fifo_pc[rd_ptr]    : '0;
  assign if_instr  = if_valid ? fifo_instr[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Storage needs no reset: entries are only visible once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= tag_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      tag_pc  <= '0;
      discard <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (redirect) begin
      // Flush wins over any push; a response already owed by memory is marked stale.
      pc_q   <= npc_i;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_gnt) begin
            state   <= WAIT;
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state   <= REQ;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case (state)
        IDLE: begin
          if (count < DEPTH_C) state <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            tag_pc <= pc_q;
            pc_q   <= pc_q + 32'd1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= (count_next < DEPTH_C) ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch : memory model + scoreboard bench for pc_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] npc_i;
  logic [31:0] pc_o;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  pc_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .npc_i      (npc_i),
    .pc_o       (pc_o),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  typedef struct {
    logic [31:0] start;
    int          lat;
    int          gmod;
    int          rmod;
    int          n;
    logic [31:0] exp_last;
  } vec_t;

  item_t       sb[$];
  int          errors = 0;
  int          checks = 0;

  // stimulus knobs
  logic        gnt_en = 1'b0;
  logic        ready_en = 1'b0;
  logic        redirect_v = 1'b0;
  logic [31:0] npc_v = '0;
  int          lat = 1;

  // memory / decode model state
  logic        pend = 1'b0;
  logic        pend_live = 1'b0;
  logic [31:0] pend_addr = '0;
  int          wait_cnt = 0;
  logic [31:0] exp_pc = '0;
  logic        gnt_fire = 1'b0;
  logic [31:0] last_gnt_addr = '0;
  int          rx = 0;
  logic [31:0] first_pc = '0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_instr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend = 1'b0; pend_live = 1'b0; wait_cnt = 0;
    sb.delete();
    exp_pc = 32'h0;
    redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
  endtask

  // One clock: drive inputs at negedge, score the edge, then wait for posedge.
  task automatic cycle();
    item_t e;
    @(negedge clk);
    redirect    = redirect_v;
    npc_i       = npc_v;
    if_ready    = ready_en;
    imem_gnt    = imem_req & gnt_en & ~pend;
    imem_rvalid = pend && (wait_cnt == 1);
    imem_rdata  = pend_addr + 32'd100;
    if (if_valid && if_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got pc %h instr %h expected no transfer", if_pc, if_instr);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", if_pc, e.pc);
        chk("xfer_instr", if_instr, e.instr);
      end
      rx++;
      if (rx == 1) first_pc = if_pc;
      last_pc = if_pc;
      last_instr = if_instr;
    end
    if (redirect) sb.delete();
    if (imem_rvalid) begin
      if (pend_live && !redirect) sb.push_back({pend_addr, pend_addr + 32'd100});
      pend = 1'b0;
    end else if (pend) begin
      wait_cnt--;
      if (redirect) pend_live = 1'b0;
    end
    gnt_fire = imem_gnt;
    if (imem_gnt) begin
      chk("fetch_addr", imem_addr, exp_pc);
      last_gnt_addr = imem_addr;
      pend = 1'b1; pend_addr = imem_addr; wait_cnt = lat; pend_live = ~redirect;
      exp_pc = imem_addr + 32'd1;
    end
    if (redirect) exp_pc = npc_i;
    @(posedge clk);
  endtask

  task automatic run_until(input int n, input int gmod, input int rmod, input string name);
    int c;
    c = 0;
    while (rx < n && c < 2000) begin
      gnt_en   = ((c % gmod) == 0);
      ready_en = ((c % rmod) == 0);
      cycle();
      c++;
    end
    if (rx < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d transfers expected %0d", name, rx, n);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_v = 1'b1; npc_v = target;
    cycle();
    redirect_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   rx0;
    int   c;
    vecs[0] = '{32'h0000_1000, 1, 1, 1, 6, 32'h0000_1005};
    vecs[1] = '{32'h0000_2000, 2, 2, 1, 5, 32'h0000_2004};
    vecs[2] = '{32'h0000_3000, 1, 1, 3, 6, 32'h0000_3005};
    vecs[3] = '{32'hFFFF_FFFE, 3, 1, 2, 4, 32'h0000_0001};

    rst_n = 1'b1;
    npc_i = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // sequential fetch, 1-cycle memory
    lat = 1; rx = 0;
    run_until(3, 1, 1, "seq");
    chk("seq_first_pc", first_pc, 32'h0);
    chk("seq_last_pc", last_pc, 32'h2);
    chk("seq_last_instr", last_instr, 32'd102);

    // backpressure: buffer fills, requests stop
    gnt_en = 1'b1; ready_en = 1'b0;
    repeat (12) cycle();
    #1;
    chk("bp_req_low", 32'(imem_req), 32'h0);
    chk("bp_valid", 32'(if_valid), 32'h1);
    chk("bp_head_pc", if_pc, 32'h3);
    run_until(7, 1, 1, "bp_resume");
    chk("bp_last_pc", last_pc, 32'h6);

    // asynchronous reset while a response is outstanding
    lat = 3; gnt_en = 1'b1; ready_en = 1'b1;
    c = 0;
    do begin cycle(); c++; end while (!gnt_fire && c < 50);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pc_o", pc_o, 32'h0);
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_valid", 32'(if_valid), 32'h0);
    chk("midrst_pc", if_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_req", 32'(imem_req), 32'h1);
    chk("midrst_rel_addr", imem_addr, 32'h0);

    // redirect while addr 5 is outstanding
    c = 0;
    do begin cycle(); c++; end while (!(gnt_fire && last_gnt_addr == 32'h5) && c < 200);
    chk("wait_gnt5", last_gnt_addr, 32'h5);
    do_redirect(32'h40);
    rx = 0;
    run_until(1, 1, 1, "rd_wait");
    chk("rd_wait_pc", first_pc, 32'h40);

    // redirect in REQ without grant, then redirect coinciding with grant
    lat = 1; gnt_en = 1'b0; ready_en = 1'b1;
    repeat (6) cycle();
    #1;
    chk("rd_req_held", 32'(imem_req), 32'h1);
    do_redirect(32'h80);
    #1;
    chk("rd_req_addr", imem_addr, 32'h80);
    gnt_en = 1'b1;
    do_redirect(32'h90);
    chk("rd_gnt_addr", last_gnt_addr, 32'h80);
    rx = 0;
    run_until(1, 1, 1, "rd_gnt");
    chk("rd_gnt_pc", first_pc, 32'h90);

    // redirect with full buffer and decode accepting
    lat = 1; gnt_en = 1'b1; ready_en = 1'b0;
    repeat (10) cycle();
    #1;
    chk("full_req_low", 32'(imem_req), 32'h0);
    rx0 = rx;
    gnt_en = 1'b0; ready_en = 1'b1;
    do_redirect(32'h200);
    #1;
    chk("full_rd_xfers", 32'(rx - rx0), 32'h1);
    chk("full_rd_valid", 32'(if_valid), 32'h0);
    cycle();
    #1;
    chk("full_rd_valid2", 32'(if_valid), 32'h0);
    chk("full_rd_xfers2", 32'(rx - rx0), 32'h1);

    // table of sequential runs with varied latency, grant and ready patterns
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      gnt_en = 1'b1; ready_en = 1'b1;
      do_redirect(vecs[i].start);
      rx = 0;
      run_until(vecs[i].n, vecs[i].gmod, vecs[i].rmod, "vec");
      chk("vec_first_pc", first_pc, vecs[i].start);
      chk("vec_last_pc", last_pc, vecs[i].exp_last);
      chk("vec_last_instr", last_instr, vecs[i].exp_last + 32'd100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
